// File: rtl/sprite_line_buffer_n.sv
// Rotating sprite line buffers: planar words are expanded into per-pixel writes
// while an independent scanout reads and clears the display-side buffer.
//
// state   | meaning
// S_INIT  | clearing every address of every buffer, one address per cycle
// S_IDLE  | waiting for a write request (WR_REQ != WR_ACK)
// S_BURST | writing one pixel per cycle of the latched word
module sprite_line_buffer_n #(
  parameter int PLANES       = 4,
  parameter int PIX_PER_WORD = 16,
  parameter int COLOR_W      = 4,
  parameter int ADDR_W       = 10,
  parameter int NUM_BUF      = 3,
  parameter int FIRST_WINS   = 0,
  parameter int SCAN_START   = 249
) (
  input  logic                             i_clk_96m,
  input  logic                             i_reset_n,
  input  logic                             i_ce_pix,
  input  logic                             i_line_start,
  input  logic                             i_nl,
  input  logic                             i_wr_req,
  output logic                             o_wr_ack,
  input  logic [PLANES*PIX_PER_WORD-1:0]   i_data_in,
  input  logic [COLOR_W-1:0]               i_color_in,
  input  logic [ADDR_W-1:0]                i_pos_in,
  input  logic                             i_flip_in,
  output logic                             o_busy,
  output logic [COLOR_W+PLANES-1:0]        o_pix_out
);

  localparam int PIX_W    = COLOR_W + PLANES;
  localparam int LINE_LEN = 1 << ADDR_W;
  localparam int IDX_W    = (NUM_BUF > 2) ? 2 : 1;
  localparam int CNT_W    = $clog2(PIX_PER_WORD);

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;

  logic [1:0]                       r_state;
  logic [ADDR_W-1:0]                r_init_addr;
  logic                             r_wr_ack;
  logic [PLANES*PIX_PER_WORD-1:0]   r_data;
  logic [COLOR_W-1:0]               r_color;
  logic [ADDR_W-1:0]                r_wpos;
  logic                             r_flip;
  logic [IDX_W-1:0]                 r_buf;
  logic [CNT_W-1:0]                 r_cnt;
  logic [IDX_W-1:0]                 r_scan_idx;
  logic [ADDR_W-1:0]                r_scan_pos;
  logic [PIX_W-1:0]                 r_pix_out;
  logic [PIX_W-1:0]                 r_mem [0:NUM_BUF-1][0:LINE_LEN-1];

  logic [CNT_W-1:0]  w_bit;
  logic [PLANES-1:0] w_planes;
  logic [PLANES-1:0] w_dst_planes;
  logic              w_blocked;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_scan_addr;
  logic              w_scan_rd;
  logic [IDX_W-1:0]  w_scan_next;
  logic [IDX_W-1:0]  w_wr_idx;

  // r_cnt counts down from PIX_PER_WORD-1, so unflipped pixel order reads bit r_cnt
  assign w_bit = r_flip ? (CNT_W'(PIX_PER_WORD - 1) - r_cnt) : r_cnt;

  for (genvar p = 0; p < PLANES; p++) begin : g_plane
    logic [PIX_PER_WORD-1:0] w_word;
    assign w_word      = r_data[p*PIX_PER_WORD +: PIX_PER_WORD];
    assign w_planes[p] = w_word[w_bit];
  end

  assign w_dst_planes = r_mem[r_buf][r_wpos][PLANES-1:0];
  assign w_blocked    = (FIRST_WINS != 0) && (|w_dst_planes);
  assign w_wr_en      = (r_state == S_BURST) && (|w_planes) && !w_blocked;

  assign w_scan_addr = r_scan_pos ^ {ADDR_W{i_nl}};
  assign w_scan_rd   = i_ce_pix && !i_line_start && (r_state != S_INIT);
  assign w_scan_next = (r_scan_idx == IDX_W'(NUM_BUF - 1)) ? '0 : r_scan_idx + 1'b1;
  assign w_wr_idx    = (r_scan_idx == '0) ? IDX_W'(NUM_BUF - 1) : r_scan_idx - 1'b1;

  // Burst write is issued after the scan clear so it wins on a shared address
  always_ff @(posedge i_clk_96m) begin
    if (r_state == S_INIT) begin
      for (int b = 0; b < NUM_BUF; b++) begin
        r_mem[b][r_init_addr] <= '0;
      end
    end else begin
      if (w_scan_rd) begin
        r_mem[r_scan_idx][w_scan_addr] <= '0;
      end
      if (w_wr_en) begin
        r_mem[r_buf][r_wpos] <= {r_color, w_planes};
      end
    end
  end

  always_ff @(posedge i_clk_96m or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_INIT;
      r_init_addr <= '0;
      r_wr_ack    <= 1'b0;
      r_data      <= '0;
      r_color     <= '0;
      r_wpos      <= '0;
      r_flip      <= 1'b0;
      r_buf       <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_init_addr <= r_init_addr + 1'b1;
          if (r_init_addr == '1) begin
            r_state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (i_wr_req != r_wr_ack) begin
            r_wr_ack <= i_wr_req;
            r_data   <= i_data_in;
            r_color  <= i_color_in;
            r_wpos   <= i_pos_in;
            r_flip   <= i_flip_in;
            r_buf    <= w_wr_idx;
            r_cnt    <= CNT_W'(PIX_PER_WORD - 1);
            r_state  <= S_BURST;
          end
        end
        S_BURST: begin
          r_wpos <= r_wpos + 1'b1;
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  always_ff @(posedge i_clk_96m or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_scan_idx <= '0;
      r_scan_pos <= '0;
      r_pix_out  <= '0;
    end else begin
      if (i_line_start) begin
        r_scan_idx <= w_scan_next;
        r_scan_pos <= ADDR_W'(SCAN_START);
      end else if (i_ce_pix) begin
        r_scan_pos <= r_scan_pos + 1'b1;
        r_pix_out  <= r_mem[r_scan_idx][w_scan_addr];
      end
      if (r_state == S_INIT) begin
        r_pix_out <= '0;
      end
    end
  end

  assign o_wr_ack  = r_wr_ack;
  assign o_busy    = (r_state != S_IDLE);
  assign o_pix_out = r_pix_out;

endmodule

// File: tb/tb_sprite_line_buffer_n.sv
// Directed bench for sprite_line_buffer_n: two instances (later-wins and first-wins)
// share all stimulus; scanned lines are captured and compared against hand tables.
module tb_sprite_line_buffer_n;
  localparam int LEN        = 1024;
  localparam int SCAN_START = 249;

  typedef struct {
    int         pos;
    logic [7:0] e0;
    logic [7:0] e1;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0;
  logic        ls = 1'b0;
  logic        nl = 1'b0;
  logic        req = 1'b0;
  logic        flip = 1'b0;
  logic [63:0] data = '0;
  logic [3:0]  color = '0;
  logic [9:0]  pos = '0;
  logic        ack0, ack1, busy0, busy1;
  logic [7:0]  pix0, pix1;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  cap0 [LEN];
  logic [7:0]  cap1 [LEN];
  vec_t        vt [21];

  always #5 clk = ~clk;

  sprite_line_buffer_n #(.FIRST_WINS(0)) dut (
    .i_clk_96m(clk), .i_reset_n(rst_n), .i_ce_pix(ce), .i_line_start(ls), .i_nl(nl),
    .i_wr_req(req), .o_wr_ack(ack0), .i_data_in(data), .i_color_in(color),
    .i_pos_in(pos), .i_flip_in(flip), .o_busy(busy0), .o_pix_out(pix0)
  );

  sprite_line_buffer_n #(.FIRST_WINS(1)) dut_fw (
    .i_clk_96m(clk), .i_reset_n(rst_n), .i_ce_pix(ce), .i_line_start(ls), .i_nl(nl),
    .i_wr_req(req), .o_wr_ack(ack1), .i_data_in(data), .i_color_in(color),
    .i_pos_in(pos), .i_flip_in(flip), .o_busy(busy1), .o_pix_out(pix1)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reset has just been released at a falling edge; k counts rising edges since
  task automatic init_seq;
    for (int k = 1; k <= 1025; k++) begin
      tick;
      if (k == 10) req = ~req;
      if (k == 1023) begin
        check("init_busy_hi", 32'(busy0), 32'd1);
        check("init_busy_hi_fw", 32'(busy1), 32'd1);
        check("init_pix_zero", 32'(pix0), 32'd0);
      end
      if (k == 1024) begin
        check("init_busy_lo", 32'(busy0), 32'd0);
        check("init_busy_lo_fw", 32'(busy1), 32'd0);
        check("init_ack_held", 32'(ack0), 32'd0);
      end
      if (k == 1025) begin
        check("init_ack", 32'(ack0), 32'(req));
        check("init_ack_fw", 32'(ack1), 32'(req));
      end
    end
  endtask

  task automatic wait_idle;
    int k = 0;
    while (busy0 && k < 2000) begin
      tick;
      k++;
    end
    check("idle_timeout", 32'(busy0), 32'd0);
  endtask

  task automatic wait_ack;
    int k = 0;
    while (ack0 !== req && k < 40) begin
      tick;
      k++;
    end
    check("ack_timeout", 32'(ack0), 32'(req));
  endtask

  // ls_at >= 0 pulses LINE_START on burst cycle ls_at+1
  task automatic do_write(input logic [63:0] d, input logic [3:0] c, input logic [9:0] p,
                          input logic f, input int ls_at);
    int k = 0;
    wait_idle;
    data = d; color = c; pos = p; flip = f;
    req = ~req;
    wait_ack;
    while (busy0 && k < 40) begin
      if (k == ls_at) ls = 1'b1;
      tick;
      ls = 1'b0;
      k++;
    end
    check("burst_done", 32'(busy0), 32'd0);
  endtask

  task automatic line_start;
    ls = 1'b1;
    tick;
    ls = 1'b0;
  endtask

  task automatic scan(input logic n);
    int sp;
    nl = n;
    for (int k = 0; k < LEN; k++) begin
      ce = 1'b1;
      tick;
      sp = (SCAN_START + k) % LEN;
      cap0[sp] = pix0;
      cap1[sp] = pix1;
    end
    ce = 1'b0;
    tick;
  endtask

  function automatic int count_nz(input bit fw);
    int c = 0;
    for (int a = 0; a < LEN; a++) begin
      if ((fw ? cap1[a] : cap0[a]) != 8'h00) c++;
    end
    return c;
  endfunction

  initial begin
    vt[0]  = '{49,   8'h00, 8'h00};
    vt[1]  = '{50,   8'h1F, 8'h1F};
    vt[2]  = '{57,   8'h1F, 8'h1F};
    vt[3]  = '{58,   8'h2F, 8'h1F};
    vt[4]  = '{65,   8'h2F, 8'h1F};
    vt[5]  = '{66,   8'h2F, 8'h2F};
    vt[6]  = '{73,   8'h2F, 8'h2F};
    vt[7]  = '{74,   8'h00, 8'h00};
    vt[8]  = '{99,   8'h00, 8'h00};
    vt[9]  = '{100,  8'h5F, 8'h5F};
    vt[10] = '{107,  8'h5F, 8'h5F};
    vt[11] = '{115,  8'h5F, 8'h5F};
    vt[12] = '{116,  8'h00, 8'h00};
    vt[13] = '{1019, 8'h00, 8'h00};
    vt[14] = '{1020, 8'h31, 8'h31};
    vt[15] = '{1021, 8'h00, 8'h00};
    vt[16] = '{1023, 8'h00, 8'h00};
    vt[17] = '{0,    8'h00, 8'h00};
    vt[18] = '{10,   8'h00, 8'h00};
    vt[19] = '{11,   8'h31, 8'h31};
    vt[20] = '{12,   8'h00, 8'h00};

    // Reset state, then init clear with a request raised mid-init
    tick; tick;
    check("rst_busy", 32'(busy0), 32'd1);
    check("rst_ack", 32'(ack0), 32'd0);
    check("rst_pix", 32'(pix0), 32'd0);
    rst_n = 1'b1;
    init_seq;

    // Four words into write buffer 2 while scan buffer is 0
    do_write({4{16'hFFFF}}, 4'd5, 10'd100, 1'b0, -1);
    do_write(64'h0000_0000_0000_8001, 4'd3, 10'd1020, 1'b0, -1);
    do_write({4{16'hFFFF}}, 4'd1, 10'd50, 1'b0, -1);
    do_write({4{16'hFFFF}}, 4'd2, 10'd58, 1'b0, -1);
    line_start;
    line_start;
    scan(1'b0);
    for (int i = 0; i < $size(vt); i++) begin
      check($sformatf("scan_pos%0d", vt[i].pos), 32'(cap0[vt[i].pos]), 32'(vt[i].e0));
      check($sformatf("scan_fw_pos%0d", vt[i].pos), 32'(cap1[vt[i].pos]), 32'(vt[i].e1));
    end
    check("scan_nz_count", 32'(count_nz(1'b0)), 32'd42);
    check("scan_fw_nz_count", 32'(count_nz(1'b1)), 32'd42);

    // Same buffer one frame later must have been cleared by the scan
    line_start; line_start; line_start;
    scan(1'b0);
    check("rescan_nz_count", 32'(count_nz(1'b0)), 32'd0);
    check("rescan_fw_nz_count", 32'(count_nz(1'b1)), 32'd0);

    // Flipped single pixel at 0, scanned with inverted addressing
    do_write(64'h0000_0000_0000_0001, 4'd7, 10'd0, 1'b1, -1);
    line_start; line_start;
    scan(1'b1);
    check("flip_nl_1023", 32'(cap0[1023]), 32'h71);
    check("flip_nl_0", 32'(cap0[0]), 32'h00);
    check("flip_nl_1008", 32'(cap0[1008]), 32'h00);
    check("flip_nl_nz_count", 32'(count_nz(1'b0)), 32'd1);
    check("flip_nl_fw_1023", 32'(cap1[1023]), 32'h71);
    nl = 1'b0;

    // LINE_START on burst cycle 3 must not retarget the burst
    do_write({4{16'hFFFF}}, 4'd6, 10'd300, 1'b0, 2);
    line_start;
    scan(1'b0);
    check("retarget_300", 32'(cap0[300]), 32'h6F);
    check("retarget_302", 32'(cap0[302]), 32'h6F);
    check("retarget_303", 32'(cap0[303]), 32'h6F);
    check("retarget_315", 32'(cap0[315]), 32'h6F);
    check("retarget_316", 32'(cap0[316]), 32'h00);
    check("retarget_nz_count", 32'(count_nz(1'b0)), 32'd16);
    check("retarget_fw_nz_count", 32'(count_nz(1'b1)), 32'd16);

    // Reset mid-burst: burst abandoned, request raised during init is served after it
    wait_idle;
    data = {4{16'hFFFF}}; color = 4'd9; pos = 10'd500; flip = 1'b0;
    req = ~req;
    wait_ack;
    tick; tick;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy0), 32'd1);
    check("midrst_ack", 32'(ack0), 32'd0);
    check("midrst_pix", 32'(pix0), 32'd0);
    tick; tick;
    rst_n = 1'b1;
    init_seq;
    wait_idle;
    line_start; line_start;
    scan(1'b0);
    check("post_rst_500", 32'(cap0[500]), 32'h9F);
    check("post_rst_515", 32'(cap0[515]), 32'h9F);
    check("post_rst_nz_count", 32'(count_nz(1'b0)), 32'd16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sprite_line_buffer_n.md
SPRITE_LINE_BUFFER_N -- requirements
Module: sprite_line_buffer_n

Interface
REQ-001 Parameter PLANES, default 4: bitplanes per pixel, legal 1..8.
REQ-002 Parameter PIX_PER_WORD, default 16: pixels per write request, legal 8/16/32.
REQ-003 Parameter COLOR_W, default 4: palette bits per pixel.
REQ-004 Parameter ADDR_W, default 10: line address width; line length 2^ADDR_W.
REQ-005 Parameter NUM_BUF, default 3: rotating line buffers, legal 2..4.
REQ-006 Parameter FIRST_WINS, default 0: 0 = later opaque pixel overwrites; 1 = existing opaque pixel kept.
REQ-007 Parameter SCAN_START, default 249: scan position loaded at line start.
REQ-008 CLK_96M  in  1  sole clock; all logic on its rising edge.
REQ-009 RESET_N  in  1  reset; asynchronous, active-low.
REQ-010 CE_PIX  in  1  pixel enable for scanout.
REQ-011 LINE_START  in  1  single-cycle pulse, new scanline.
REQ-012 NL  in  1  scan direction; 1 = address bits inverted.
REQ-013 WR_REQ  in  1  toggle request.
REQ-014 WR_ACK  out  1  toggle acknowledge.
REQ-015 DATA_IN  in  PLANES*PIX_PER_WORD  planar pixel word; plane p at bits [p*PIX_PER_WORD +: PIX_PER_WORD].
REQ-016 COLOR_IN  in  COLOR_W  palette for the whole word.
REQ-017 POS_IN  in  ADDR_W  line position of left-most pixel.
REQ-018 FLIP_IN  in  1  1 = pixel order reversed.
REQ-019 BUSY  out  1  high during init clear or write burst.
REQ-020 PIX_OUT  out  COLOR_W+PLANES  scanned pixel {color, planes}.

Function
REQ-021 Pixel i (i=0 left-most) of a word SHALL be bit PIX_PER_WORD-1-i of each plane, plane 0 as LSB; with FLIP_IN=1, bit i.
REQ-022 A pixel SHALL be transparent when all plane bits are 0; transparent pixels are never written.
REQ-023 States: INIT, IDLE, BURST.
REQ-024 INIT: entered on reset; writes 0 to every address of every buffer, one address per cycle across all buffers in parallel, 2^ADDR_W cycles; then IDLE.
REQ-025 IDLE: when WR_REQ != WR_ACK, latch DATA_IN, COLOR_IN, POS_IN, FLIP_IN and current write-buffer index; WR_ACK <= WR_REQ next cycle; go BURST.
REQ-026 BURST: exactly PIX_PER_WORD cycles, one pixel per cycle, position incrementing modulo 2^ADDR_W (wrap 2^ADDR_W-1 -> 0); then IDLE; back-to-back request accepted on the IDLE cycle after.
REQ-027 FIRST_WINS=1: opaque pixel SHALL NOT be written where destination plane bits are nonzero (read-modify-write pipelined, one pixel/cycle sustained; same-address hazard within a burst impossible).
REQ-028 Requests arriving in INIT or BURST SHALL be held pending, not dropped.
REQ-029 Write buffer = (scan_idx + NUM_BUF - 1) mod NUM_BUF; data written during line L appears NUM_BUF-1 lines later.
REQ-030 LINE_START: scan_idx <= (scan_idx+1) mod NUM_BUF; scan_pos <= SCAN_START; takes priority over CE_PIX same cycle.
REQ-031 LINE_START during BURST SHALL NOT retarget the burst; latched buffer index kept.
REQ-032 Each CE_PIX (no LINE_START): PIX_OUT <= buffer[scan_idx][scan_pos ^ {ADDR_W{NL}}]; that location cleared to 0; scan_pos increments, wrapping.
REQ-033 Scan read/clear and burst write never address the same buffer except NUM_BUF=2 burst straddling LINE_START; then write wins if same address same cycle.
REQ-034 INIT: PIX_OUT held 0, scan_pos/scan_idx still track LINE_START/CE_PIX.

Reset
REQ-035 RESET_N low SHALL immediately force: WR_ACK=0, PIX_OUT=0, BUSY=1, state INIT, scan_idx=0, scan_pos=0, INIT address 0.
REQ-036 Reset mid-burst SHALL abandon the burst; pending request re-evaluated after INIT.

Verification
REQ-037 Reset release, defaults -> BUSY high exactly 1024 cycles, WR_ACK stays 0 while WR_REQ toggled at cycle 10, ACK toggles cycle 1025/1026.
REQ-038 Word planes all 0xFFFF, COLOR_IN=5, POS_IN=100, FLIP_IN=0, then 2 LINE_STARTs, scan -> PIX_OUT=0x5F at positions 100..115, 0 elsewhere; rescan next frame of same buffer -> all 0.
REQ-039 POS_IN=1020, plane0=0x8001 -> pixels written at 1020 and 1019? no: 1020 and 1023+? expected: bit15 at 1020, bit0 at 11 (wrap) only.
REQ-040 FIRST_WINS=1: word A color 1 at 50, word B color 2 at 58 -> 58..65 hold color 1, 66..73 color 2; FIRST_WINS=0 -> 58..73 color 2.
REQ-041 FLIP_IN=1, plane0=0x0001, POS_IN=0 -> opaque pixel at 0; NL=1 -> that pixel scanned at scan_pos 1023.
REQ-042 LINE_START on BURST cycle 3 -> remaining 13 pixels land in the originally latched buffer, appear on same display line as first 3.
